// File: rtl/lcd_bus_driver.sv
// -----------------------------------------------------------------------------
// lcd_bus_driver
//
// Bus-timing stage between the LCD text sequencer and an HD44780-style
// character LCD. One byte plus register-select is captured per start edge and
// driven onto the LCD pins with setup, enable-pulse and hold timing. The stage
// then waits out the controller's execution time and pulses oDone so the
// sequencer can issue the next byte. The interface is write-only (LCD_RW = 0).
//
// Optional feature (compile-time macro LCD_LONG_CMD_DLY_EN):
//   defined   - clear/home commands (RS=0, DATA[7:1]=0) wait T_CLEAR cycles
//   undefined - every byte waits T_EXEC cycles; T_CLEAR is not used
//
// Ports:
//   iCLK      in   system clock
//   iRST      in   synchronous reset, active-high
//   iDATA     in   byte to write
//   iRS       in   register select (0 = command, 1 = data)
//   iStart    in   request level; a transaction starts on its rising edge
//   oDone     out  one-cycle pulse when the transaction incl. wait is complete
//   oBusy     out  high from capture until oDone inclusive
//   LCD_DATA  out  LCD data bus
//   LCD_RW    out  LCD read/write, constant 0
//   LCD_EN    out  LCD enable strobe
//   LCD_RS    out  LCD register select
// -----------------------------------------------------------------------------
module lcd_bus_driver #(
    parameter int T_SETUP   = 2,
    parameter int T_EN_HIGH = 16,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int CNT_W     = 18
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HIGH,
        S_HOLD,
        S_EXEC,
        S_DONE
    } state_t;

    // Each timed state counts 0..N-1, so the exit test compares against N-1.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);

    // Elaboration-time sanity checks on the timing parameters.
    localparam int MAX_WAIT = (T_EXEC > T_CLEAR) ? T_EXEC : T_CLEAR;
    if (((MAX_WAIT - 1) >> CNT_W) != 0) begin : g_cnt_w_too_small
        $error("CNT_W too narrow for max(T_EXEC, T_CLEAR)");
    end
    if (T_SETUP < 1 || T_EN_HIGH < 1 || T_HOLD < 1 || T_EXEC < 1 || T_CLEAR < 1)
    begin : g_bad_timing
        $error("all timing parameters must be at least 1");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] wait_last;
    logic             start_edge;

`ifdef LCD_LONG_CMD_DLY_EN
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);
    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    assign wait_last = (!rs_q && (data_q[7:1] == 7'b0000000)) ? CLEAR_LAST : EXEC_LAST;
`else
    assign wait_last = EXEC_LAST;
`endif

    // The sequencer holds iStart until oDone, so only a rising edge may start
    // a transaction; a level held through DONE must not retrigger.
    assign start_edge = iStart & ~start_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement leaves one unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        done_d  = 1'b0;
        busy_d  = busy_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    data_d  = iDATA;
                    rs_d    = iRS;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_EN_HIGH;
                end
            end
            S_EN_HIGH: begin
                if (cnt_q == EN_LAST) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == wait_last) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // LCD_DATA/LCD_RS deliberately keep the captured byte.
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= iStart;
            done_q  <= done_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign oDone    = done_q;
    assign oBusy    = busy_q;
    assign LCD_DATA = data_q;
    assign LCD_EN   = en_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_driver
//
// Self-checking bench for lcd_bus_driver using short simulation timings.
// Each driven transaction pushes its expected EN pulse position, byte and oDone
// cycle onto a scoreboard; a negedge monitor records observed EN pulses and
// oDone pulses, and each test pops and compares them.
// -----------------------------------------------------------------------------
module tb_lcd_bus_driver;

    localparam int T_SETUP   = 1;
    localparam int T_EN_HIGH = 4;
    localparam int T_HOLD    = 1;
    localparam int T_EXEC    = 10;
    localparam int T_CLEAR   = 50;
    localparam int CNT_W     = 18;
    localparam int LAT_EXEC  = T_SETUP + T_EN_HIGH + T_HOLD + T_EXEC;   // 16
    localparam int LAT_CLEAR = T_SETUP + T_EN_HIGH + T_HOLD + T_CLEAR;  // 56

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        int         en_start;
        int         en_width;
        int         done_cyc;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       rs_in;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_rs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    txn_t exp_q[$];
    txn_t en_q[$];
    int   done_q[$];

    lcd_bus_driver #(
        .T_SETUP  (T_SETUP),
        .T_EN_HIGH(T_EN_HIGH),
        .T_HOLD   (T_HOLD),
        .T_EXEC   (T_EXEC),
        .T_CLEAR  (T_CLEAR),
        .CNT_W    (CNT_W)
    ) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iDATA   (data_in),
        .iRS     (rs_in),
        .iStart  (start),
        .oDone   (done),
        .oBusy   (busy),
        .LCD_DATA(lcd_data),
        .LCD_RW  (lcd_rw),
        .LCD_EN  (lcd_en),
        .LCD_RS  (lcd_rs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records EN pulses (byte, start cycle, width), oDone cycles and
    // any cycle where LCD_RW is not 0.
    bit   mon_en  = 1'b0;
    bit   en_prev = 1'b0;
    txn_t en_cur;
    int   rw_bad  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (lcd_en === 1'b1 && !en_prev) begin
                en_cur          = '0;
                en_cur.rs       = lcd_rs;
                en_cur.data     = lcd_data;
                en_cur.en_start = cyc;
            end
            if (lcd_en !== 1'b1 && en_prev) begin
                en_cur.en_width = cyc - en_cur.en_start;
                en_q.push_back(en_cur);
            end
            if (done === 1'b1) done_q.push_back(cyc);
            if (lcd_rw !== 1'b0) rw_bad++;
            en_prev = (lcd_en === 1'b1);
        end
    end

    // Drives one start edge and pushes the expected result. Returns the
    // capture cycle; on return the caller is just after that cycle's negedge.
    task automatic drive_start(input logic r, input logic [7:0] d, output int c0);
        int lat;
        @(negedge clk); #1;
        rs_in   = r;
        data_in = d;
        start   = 1'b1;
        @(negedge clk); #1;
        c0  = cyc;
        lat = LAT_EXEC;
`ifdef LCD_LONG_CMD_DLY_EN
        if (r == 1'b0 && d[7:1] == 7'd0) lat = LAT_CLEAR;
`endif
        exp_q.push_back('{rs: r, data: d, en_start: c0 + T_SETUP,
                          en_width: T_EN_HIGH, done_cyc: c0 + lat});
    endtask

    // Bounded wait until the monitor has seen at least 'want' oDone pulses.
    task automatic wait_done_cnt(input int want);
        for (int i = 0; i < 400; i++) begin
            if (done_q.size() >= want) break;
            @(negedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rs_in = 1'b0; data_in = 8'h00;
        idle_cycles(3);
        checks++;
        if ({done, busy, lcd_en, lcd_rs, lcd_rw, lcd_data} !== 13'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {done, busy, lcd_en, lcd_rs, lcd_rw, lcd_data}, 13'b0);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        idle_cycles(4);
        checks++;
        if ({done, busy, lcd_en} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: done/busy/en=%b expected 000", {done, busy, lcd_en});
        end
    endtask

    // Single data write 0x150 checked cycle by cycle; iStart drops mid-way.
    task automatic test_single_write();
        int   c0;
        txn_t x, o;
        logic [11:0] got, want;
        drive_start(1'b1, 8'h50, c0);
        checks++;
        if ({busy, done, lcd_en, lcd_rs, lcd_data} !== {4'b1001, 8'h50}) begin
            failures++;
            $display("FAIL single_capture: got %h expected %h",
                     {busy, done, lcd_en, lcd_rs, lcd_data}, {4'b1001, 8'h50});
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); #1;
            if (k == 2) start = 1'b0;
            got  = {lcd_en, busy, done, lcd_rs, lcd_data};
            want = {(k >= 1 && k <= 4), (k <= 16), (k == 16), 1'b1, 8'h50};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL single_cycle%0d: en/busy/done/rs/data got %h expected %h",
                         k, got, want);
            end
        end
        checks++;
        if (exp_q.size() == 0 || en_q.size() == 0 || done_q.size() == 0) begin
            failures++;
            $display("FAIL single_sb: missing record exp=%0d en=%0d done=%0d",
                     exp_q.size(), en_q.size(), done_q.size());
        end else begin
            x = exp_q.pop_front();
            o = en_q.pop_front();
            o.done_cyc = done_q.pop_front();
            if (o !== x) begin
                failures++;
                $display("FAIL single_sb: got %h expected %h", o, x);
            end
        end
    endtask

    // iStart held high through and after oDone, then a fresh edge with 0x038.
    task automatic test_hold_start();
        int   c0, c1;
        txn_t x, o;
        drive_start(1'b1, 8'h41, c0);
        wait_done_cnt(1);
        idle_cycles(10);
        checks++;
        if ({en_q.size(), done_q.size()} !== {32'd1, 32'd1} ||
            {busy, lcd_rs, lcd_data} !== {2'b01, 8'h41}) begin
            failures++;
            $display("FAIL hold_no_retrigger: pulses=%0d dones=%0d busy/rs/data=%h expected 1 1 %h",
                     en_q.size(), done_q.size(), {busy, lcd_rs, lcd_data}, {2'b01, 8'h41});
        end
        start = 1'b0;
        drive_start(1'b0, 8'h38, c1);
        checks++;
        if ({busy, lcd_rs, lcd_data} !== {2'b10, 8'h38}) begin
            failures++;
            $display("FAIL hold_second_capture: got %h expected %h",
                     {busy, lcd_rs, lcd_data}, {2'b10, 8'h38});
        end
        wait_done_cnt(2);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (exp_q.size() == 0 || en_q.size() == 0 || done_q.size() == 0) begin
                failures++;
                $display("FAIL hold_sb%0d: missing record exp=%0d en=%0d done=%0d",
                         i, exp_q.size(), en_q.size(), done_q.size());
            end else begin
                x = exp_q.pop_front();
                o = en_q.pop_front();
                o.done_cyc = done_q.pop_front();
                if (o !== x) begin
                    failures++;
                    $display("FAIL hold_sb%0d: got %h expected %h", i, o, x);
                end
            end
        end
    endtask

    // A new rising edge on iStart at cycle 5 of a transaction is ignored.
    task automatic test_ignore_start();
        int   c0;
        txn_t x, o;
        drive_start(1'b1, 8'h33, c0);
        idle_cycles(3);
        start = 1'b0;
        idle_cycles(1);
        start = 1'b1;
        wait_done_cnt(1);
        idle_cycles(10);
        checks++;
        if ({en_q.size(), done_q.size()} !== {32'd1, 32'd1}) begin
            failures++;
            $display("FAIL ignore_single: pulses=%0d dones=%0d expected 1 1",
                     en_q.size(), done_q.size());
        end
        start = 1'b0;
        checks++;
        if (exp_q.size() == 0 || en_q.size() == 0 || done_q.size() == 0) begin
            failures++;
            $display("FAIL ignore_sb: missing record exp=%0d en=%0d done=%0d",
                     exp_q.size(), en_q.size(), done_q.size());
        end else begin
            x = exp_q.pop_front();
            o = en_q.pop_front();
            o.done_cyc = done_q.pop_front();
            if (o !== x) begin
                failures++;
                $display("FAIL ignore_sb: got %h expected %h", o, x);
            end
        end
        en_q.delete();
        done_q.delete();
    endtask

    // Reset while EN is high aborts the transaction without oDone.
    task automatic test_reset_mid();
        int   c0, c1, w;
        txn_t x, o;
        drive_start(1'b1, 8'h5A, c0);
        idle_cycles(2);
        checks++;
        if (lcd_en !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_en_high: got %b expected 1", lcd_en);
        end
        rst   = 1'b1;
        start = 1'b0;
        idle_cycles(1);
        checks++;
        if ({done, busy, lcd_en, lcd_rs, lcd_rw, lcd_data} !== 13'b0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %b expected %b",
                     {done, busy, lcd_en, lcd_rs, lcd_rw, lcd_data}, 13'b0);
        end
        rst = 1'b0;
        idle_cycles(25);
        w = (en_q.size() > 0) ? en_q[0].en_width : -1;
        checks++;
        if (done_q.size() != 0 || en_q.size() != 1 || w != 2) begin
            failures++;
            $display("FAIL rstmid_abort: dones=%0d pulses=%0d width=%0d expected 0 1 2",
                     done_q.size(), en_q.size(), w);
        end
        exp_q.delete();
        en_q.delete();
        done_q.delete();
        drive_start(1'b1, 8'hA5, c1);
        wait_done_cnt(1);
        start = 1'b0;
        checks++;
        if (exp_q.size() == 0 || en_q.size() == 0 || done_q.size() == 0) begin
            failures++;
            $display("FAIL rstmid_fresh_sb: missing record exp=%0d en=%0d done=%0d",
                     exp_q.size(), en_q.size(), done_q.size());
        end else begin
            x = exp_q.pop_front();
            o = en_q.pop_front();
            o.done_cyc = done_q.pop_front();
            if (o !== x) begin
                failures++;
                $display("FAIL rstmid_fresh_sb: got %h expected %h", o, x);
            end
        end
    endtask

    // Clear/home commands versus ordinary bytes near the DATA[7:1]=0 boundary.
    task automatic test_long_cmd();
        logic [8:0] cmds [5];
        int   c0;
        txn_t x, o;
        cmds = '{9'h001, 9'h101, 9'h002, 9'h003, 9'h004};
        foreach (cmds[i]) begin
            drive_start(cmds[i][8], cmds[i][7:0], c0);
            wait_done_cnt(1);
            start = 1'b0;
            checks++;
            if (exp_q.size() == 0 || en_q.size() == 0 || done_q.size() == 0) begin
                failures++;
                $display("FAIL long_cmd_%h: missing record exp=%0d en=%0d done=%0d",
                         cmds[i], exp_q.size(), en_q.size(), done_q.size());
            end else begin
                x = exp_q.pop_front();
                o = en_q.pop_front();
                o.done_cyc = done_q.pop_front();
                if (o !== x) begin
                    failures++;
                    $display("FAIL long_cmd_%h: got %h expected %h (done got %0d expected %0d)",
                             cmds[i], o, x, o.done_cyc - c0, x.done_cyc - c0);
                end
            end
        end
    endtask

    // Sequencer-style Start/Done handshake over an init sequence.
    task automatic test_back_to_back();
        logic [8:0] seq [4];
        int   c0;
        txn_t x, o;
        seq = '{9'h038, 9'h00C, 9'h001, 9'h006};
        foreach (seq[i]) begin
            drive_start(seq[i][8], seq[i][7:0], c0);
            wait_done_cnt(i + 1);
            start = 1'b0;
        end
        idle_cycles(5);
        checks++;
        if (en_q.size() != 4 || done_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: pulses=%0d dones=%0d expected 4 4",
                     en_q.size(), done_q.size());
        end
        foreach (seq[i]) begin
            checks++;
            if (exp_q.size() == 0 || en_q.size() == 0 || done_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_sb%0d: missing record exp=%0d en=%0d done=%0d",
                         i, exp_q.size(), en_q.size(), done_q.size());
            end else begin
                x = exp_q.pop_front();
                o = en_q.pop_front();
                o.done_cyc = done_q.pop_front();
                if (o !== x) begin
                    failures++;
                    $display("FAIL b2b_sb%0d: got %h expected %h", i, o, x);
                end
            end
        end
        checks++;
        if (rw_bad != 0) begin
            failures++;
            $display("FAIL rw_low: cycles with LCD_RW!=0 got %0d expected 0", rw_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_hold_start();
        test_ignore_start();
        test_reset_mid();
        test_long_cmd();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Bus-timing stage directly downstream of the LCD text sequencer.
- Accepts one byte plus register-select per handshake and drives the HD44780-style character-LCD pins (DATA, RS, RW, EN) with setup, enable-pulse and hold timing.
- Waits out the controller's execution time, then reports completion so the sequencer can issue the next byte.
- Write-only: LCD_RW is tied low.

Parameters:
- T_SETUP, 2: cycles RS/DATA are stable before EN rises (min 1).
- T_EN_HIGH, 16: cycles EN is held high (min 1).
- T_HOLD, 2: cycles RS/DATA are held after EN falls (min 1).
- T_EXEC, 2000: post-write wait for ordinary commands and characters (40 us at 50 MHz; min 1).
- T_CLEAR, 82000: post-write wait for clear/home commands, used only with the optional feature (min 1).
- CNT_W, 18: delay counter width; must hold max(T_EXEC, T_CLEAR).

Ports:
- iCLK  in  1  system clock
- iRST  in  1  synchronous reset, active-high
- iDATA  in  8  byte to write
- iRS  in  1  register select: 0 = command, 1 = data
- iStart  in  1  request level; a transaction starts on its rising edge
- oDone  out  1  one-cycle pulse when the transaction, including execution wait, is complete
- oBusy  out  1  high from capture until oDone inclusive
- LCD_DATA  out  8  LCD data bus
- LCD_RW  out  1  constant 0
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select

Behaviour:
- All outputs are registered. Reset, synchronous on iCLK when iRST=1, sets oDone, oBusy, LCD_DATA, LCD_EN, LCD_RS and LCD_RW to 0, state to IDLE, counter to 0, and start_q to 0.
- start_q is iStart registered every cycle. A start edge is iStart=1 and start_q=0.
- IDLE:
  - On a start edge, latch iDATA→LCD_DATA and iRS→LCD_RS, set oBusy=1 and go to SETUP. This clock edge is the capture edge (cycle 0).
  - If there is no start edge, stay in IDLE.
- SETUP: EN=0 for T_SETUP cycles, then EN_HIGH.
- EN_HIGH: EN=1 for exactly T_EN_HIGH cycles, then HOLD.
- HOLD: EN=0 for T_HOLD cycles, then EXEC.
- EXEC:
  - Wait T_wait cycles, then DONE.
  - T_wait = T_EXEC, except as set by the optional feature.
- DONE: oDone=1 for exactly one cycle. oBusy is cleared on exit. Next state is IDLE.
- Latency: oDone is high in cycle T_SETUP+T_EN_HIGH+T_HOLD+T_wait after the capture edge. With defaults this is cycle 2020.
- LCD_DATA and LCD_RS do not change between capture and the next capture, including after DONE.
- Start edges while oBusy=1 are ignored; no queuing.
- If iStart stays high through DONE, no retrigger occurs. A new transaction requires iStart low for at least one cycle. This matches the sequencer, which holds Start until Done and then drops it.
- iStart falling mid-transaction has no effect; the transaction completes.
- iRST mid-transaction, including in EN_HIGH, forces EN=0 on that edge, returns to IDLE and produces no oDone.
- The counter counts 0..N-1 per timed state and is cleared on every state change. It never wraps within a state.

Optional Feature:
- Macro: LCD_LONG_CMD_DLY_EN.
- Defined: T_wait = T_CLEAR when the captured RS=0 and DATA[7:1]=7'b0000000 (clear 0x01 or home 0x02/0x03). All other bytes use T_EXEC.
- Undefined: T_wait = T_EXEC always. T_CLEAR is unused and the comparator is absent.

Test Plan (sim params T_SETUP=1, T_EN_HIGH=4, T_HOLD=1, T_EXEC=10, T_CLEAR=50):
- Write 0x150 (RS=1, DATA=0x50) → at cycle 0 LCD_DATA=0x50 and LCD_RS=1; LCD_EN high cycles 1–4 only; oDone high in cycle 16 only; oBusy=1 cycles 0–16.
- Hold iStart high through and after oDone → no second EN pulse; then drop iStart 1 cycle, raise it with 0x038 → second transaction with LCD_RS=0, LCD_DATA=0x38.
- Toggle iStart 0→1 at cycle 5 of an active transaction → ignored; single oDone at cycle 16.
- Assert iRST in cycle 2 (EN high) → LCD_EN=0 and all outputs 0 next cycle, no oDone; a fresh start edge afterwards works normally.
- Command 0x001 with LCD_LONG_CMD_DLY_EN defined → oDone at cycle 56. Same command without the macro → cycle 16. Data 0x101 → cycle 16 in both builds.
- Back-to-back sequence 0x038, 0x00C, 0x001, 0x006 driven as Start/Done handshake → exactly four EN pulses, bytes in order, LCD_RW=0 throughout.
